// File: rtl/seq_mon_pkg.sv
// Shared defaults and result encoding for the a ##DELAY b sequence monitor.
// Pure declarations: no logic, so there is no latency or flow control here.
package seq_mon_pkg;

    localparam int DEFAULT_DELAY = 3;
    localparam int DEFAULT_CNT_W = 16;

    typedef enum logic [1:0] {
        NONE       = 2'd0,
        PASS       = 2'd1,
        FAIL_EARLY = 2'd2,
        FAIL_LATE  = 2'd3
    } result_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter that adds 0..2 per cycle, with a synchronous clear.
// The new count is visible one cycle after the increment; there is no backpressure and it holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic [1:0]   inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W:0]   sum;

    always_comb begin
        sum   = {1'b0, cnt_q} + (W+1)'(inc_i);
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (sum[W]) begin
            cnt_d = '1;
        end else begin
            cnt_d = sum[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_monitor_a3b.sv
// Overlapping a ##DELAY b implication monitor with result pulses, saturating counters and first-fail capture.
// Results are registered one cycle after the resolving edge; there is no backpressure and one attempt can start per cycle.
module seq_monitor_a3b
    import seq_mon_pkg::*;
#(
    parameter int DELAY = DEFAULT_DELAY,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             a_i,
    input  logic             b_i,
    output logic             pass_o,
    output logic             fail_o,
    output logic             fail_early_o,
    output logic             fail_late_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o,
    output logic             first_fail_o,
    output logic [CNT_W-1:0] first_fail_ts_o,
    output logic             busy_o
);

    logic [DELAY-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] ts_q, ts_d;
    logic [CNT_W-1:0] first_fail_ts_q, first_fail_ts_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             fail_early_q, fail_early_d;
    logic             fail_late_q, fail_late_d;
    logic             first_fail_q, first_fail_d;
    logic             start;
    logic             start_a;
    logic [1:0]       pass_inc;
    logic [1:0]       fail_inc;
    result_e          early_res;
    result_e          late_res;

    always_comb begin
        start   = en_i & ~clr_i & (a_i | b_i);
        start_a = start & a_i;

        early_res = (start && !a_i) ? FAIL_EARLY : NONE;
        late_res  = NONE;
        // The oldest pending bit is the attempt started DELAY cycles ago.
        if (!clr_i && pend_q[DELAY-1]) begin
            late_res = b_i ? PASS : FAIL_LATE;
        end

        pend_d = '0;
        if (!clr_i) begin
            pend_d    = pend_q << 1;
            pend_d[0] = start_a;
        end

        ts_d = ts_q + CNT_W'(1);

        fail_early_d = (early_res == FAIL_EARLY);
        fail_late_d  = (late_res == FAIL_LATE);
        pass_d       = (late_res == PASS);
        fail_d       = fail_early_d | fail_late_d;

        pass_inc = {1'b0, pass_d};
        fail_inc = {1'b0, fail_early_d} + {1'b0, fail_late_d};

        first_fail_d    = first_fail_q;
        first_fail_ts_d = first_fail_ts_q;
        if (clr_i) begin
            first_fail_d    = 1'b0;
            first_fail_ts_d = '0;
        end else if (fail_d && !first_fail_q) begin
            first_fail_d    = 1'b1;
            first_fail_ts_d = ts_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q          <= '0;
            ts_q            <= '0;
            first_fail_ts_q <= '0;
            pass_q          <= 1'b0;
            fail_q          <= 1'b0;
            fail_early_q    <= 1'b0;
            fail_late_q     <= 1'b0;
            first_fail_q    <= 1'b0;
        end else begin
            pend_q          <= pend_d;
            ts_q            <= ts_d;
            first_fail_ts_q <= first_fail_ts_d;
            pass_q          <= pass_d;
            fail_q          <= fail_d;
            fail_early_q    <= fail_early_d;
            fail_late_q     <= fail_late_d;
            first_fail_q    <= first_fail_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_pass_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr_i),
        .inc_i (pass_inc),
        .cnt_o (pass_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_fail_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr_i),
        .inc_i (fail_inc),
        .cnt_o (fail_cnt_o)
    );

    assign pass_o          = pass_q;
    assign fail_o          = fail_q;
    assign fail_early_o    = fail_early_q;
    assign fail_late_o     = fail_late_q;
    assign first_fail_o    = first_fail_q;
    assign first_fail_ts_o = first_fail_ts_q;
    assign busy_o          = |pend_q;

endmodule

// File: tb/tb_seq_monitor_a3b.sv
// Bench for seq_monitor_a3b: vector table, directed corner sequences and random stimulus vs a queue-based model.
module tb_seq_monitor_a3b;

    localparam int DELAY = 3;
    localparam int MAXC  = 65535;

    logic        clk;
    logic        rst_n;
    logic        en_i, clr_i, a_i, b_i;
    logic        pass_o, fail_o, fail_early_o, fail_late_o, first_fail_o, busy_o;
    logic [15:0] pass_cnt_o, fail_cnt_o, first_fail_ts_o;
    logic        s_pass_o, s_fail_o, s_fail_early_o, s_fail_late_o, s_first_fail_o, s_busy_o;
    logic [3:0]  s_pass_cnt_o, s_fail_cnt_o, s_first_fail_ts_o;

    int checks   = 0;
    int failures = 0;

    seq_monitor_a3b #(.DELAY(DELAY), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .clr_i(clr_i), .a_i(a_i), .b_i(b_i),
        .pass_o(pass_o), .fail_o(fail_o), .fail_early_o(fail_early_o), .fail_late_o(fail_late_o),
        .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o), .first_fail_o(first_fail_o),
        .first_fail_ts_o(first_fail_ts_o), .busy_o(busy_o)
    );

    // Narrow-counter instance sharing the same stimulus, used for saturation.
    seq_monitor_a3b #(.DELAY(DELAY), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .clr_i(clr_i), .a_i(a_i), .b_i(b_i),
        .pass_o(s_pass_o), .fail_o(s_fail_o), .fail_early_o(s_fail_early_o), .fail_late_o(s_fail_late_o),
        .pass_cnt_o(s_pass_cnt_o), .fail_cnt_o(s_fail_cnt_o), .first_fail_o(s_first_fail_o),
        .first_fail_ts_o(s_first_fail_ts_o), .busy_o(s_busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: pending attempts are kept as a queue of start cycles.
    int m_q[$];
    int m_cyc;
    int m_pass_cnt, m_fail_cnt, m_ff_ts;
    bit m_pass, m_fail, m_fe, m_fl, m_ff;

    task automatic model_reset();
        m_q.delete();
        m_cyc = 0;
        m_pass_cnt = 0; m_fail_cnt = 0; m_ff_ts = 0;
        m_pass = 0; m_fail = 0; m_fe = 0; m_fl = 0; m_ff = 0;
    endtask

    function automatic int sat(input int x);
        return (x > MAXC) ? MAXC : x;
    endfunction

    task automatic model_step(input bit en, input bit clr, input bit a, input bit b);
        bit late_p, late_f, early_f, trig;
        late_p = 0; late_f = 0; early_f = 0;
        m_pass = 0; m_fail = 0; m_fe = 0; m_fl = 0;
        if (clr) begin
            m_q.delete();
            m_pass_cnt = 0; m_fail_cnt = 0; m_ff = 0; m_ff_ts = 0;
        end else begin
            if (m_q.size() > 0 && m_q[0] == m_cyc - DELAY) begin
                void'(m_q.pop_front());
                if (b) late_p = 1; else late_f = 1;
            end
            trig    = en && (a || b);
            early_f = trig && !a;
            if (trig && a) m_q.push_back(m_cyc);
            m_pass = late_p; m_fl = late_f; m_fe = early_f; m_fail = late_f || early_f;
            m_pass_cnt = sat(m_pass_cnt + int'(late_p));
            m_fail_cnt = sat(m_fail_cnt + int'(late_f) + int'(early_f));
            if (m_fail && !m_ff) begin
                m_ff = 1;
                m_ff_ts = m_cyc % 65536;
            end
        end
        m_cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("pass_o", 32'(pass_o), 32'(m_pass));
        chk("fail_o", 32'(fail_o), 32'(m_fail));
        chk("fail_early_o", 32'(fail_early_o), 32'(m_fe));
        chk("fail_late_o", 32'(fail_late_o), 32'(m_fl));
        chk("pass_cnt_o", 32'(pass_cnt_o), 32'(m_pass_cnt));
        chk("fail_cnt_o", 32'(fail_cnt_o), 32'(m_fail_cnt));
        chk("first_fail_o", 32'(first_fail_o), 32'(m_ff));
        chk("first_fail_ts_o", 32'(first_fail_ts_o), 32'(m_ff_ts));
        chk("busy_o", 32'(busy_o), 32'(m_q.size() > 0));
    endtask

    task automatic step(input bit en, input bit clr, input bit a, input bit b);
        en_i = en; clr_i = clr; a_i = a; b_i = b;
        model_step(en, clr, a, b);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en_i = 0; clr_i = 0; a_i = 0; b_i = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        compare_model();
    endtask

    typedef struct {
        bit en, clr, a, b;
        bit p, f, fe, fl, busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit en, input bit clr, input bit a, input bit b,
                                input bit p, input bit f, input bit fe, input bit fl, input bit busy);
        vec_t v;
        v.en = en; v.clr = clr; v.a = a; v.b = b;
        v.p = p; v.f = f; v.fe = fe; v.fl = fl; v.busy = busy;
        return v;
    endfunction

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            step(vecs[i].en, vecs[i].clr, vecs[i].a, vecs[i].b);
            chk($sformatf("vec%0d.pass", i), 32'(pass_o), 32'(vecs[i].p));
            chk($sformatf("vec%0d.fail", i), 32'(fail_o), 32'(vecs[i].f));
            chk($sformatf("vec%0d.fail_early", i), 32'(fail_early_o), 32'(vecs[i].fe));
            chk($sformatf("vec%0d.fail_late", i), 32'(fail_late_o), 32'(vecs[i].fl));
            chk($sformatf("vec%0d.busy", i), 32'(busy_o), 32'(vecs[i].busy));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en_i = 0; clr_i = 0; a_i = 0; b_i = 0;
        model_reset();

        // a at cycle 0, b at cycle 3 with en low so b alone starts nothing (rows 0..4)
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        // b without a fails immediately (rows 5..6)
        vecs.push_back(mk(1, 0, 0, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        // a held 0..9, b high from 5; en drops at 10 so b alone starts nothing (rows 7..20)
        for (int c = 0; c < 14; c++) begin
            if (c < 10)
                vecs.push_back(mk(1, 0, 1, c >= 5, c >= 5, c == 3 || c == 4, 0, c == 3 || c == 4, 1));
            else if (c < 13)
                vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, c < 12));
            else
                vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        // late pass and early failure resolving in the same cycle (rows 21..25)
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

        do_reset();
        chk("reset.busy", 32'(busy_o), 0);
        chk("reset.pass_cnt", 32'(pass_cnt_o), 0);
        run_vecs(0, 4);
        chk("s1.pass_cnt", 32'(pass_cnt_o), 1);
        chk("s1.fail_cnt", 32'(fail_cnt_o), 0);

        do_reset();
        run_vecs(5, 6);
        chk("s2.fail_cnt", 32'(fail_cnt_o), 1);
        chk("s2.first_fail", 32'(first_fail_o), 1);
        chk("s2.first_fail_ts", 32'(first_fail_ts_o), 0);

        do_reset();
        run_vecs(7, 20);
        // attempts from cycles 0 and 1 miss b; those from cycles 2..9 all see it
        chk("s3.fail_cnt", 32'(fail_cnt_o), 2);
        chk("s3.pass_cnt", 32'(pass_cnt_o), 8);
        chk("s3.first_fail_ts", 32'(first_fail_ts_o), 3);

        // b is shared, so a late failure cannot coincide with an early one; the reachable overlap is pass+early fail
        do_reset();
        run_vecs(21, 25);
        chk("s4.pass_cnt", 32'(pass_cnt_o), 1);
        chk("s4.fail_cnt", 32'(fail_cnt_o), 1);

        // clear drops a pending attempt before it can resolve
        do_reset();
        step(1, 0, 1, 0);
        step(0, 1, 0, 0);
        chk("clr.busy", 32'(busy_o), 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0);
            chk("clr.no_late_fail", 32'(fail_o), 0);
        end

        // async reset with three attempts pending
        do_reset();
        step(1, 0, 0, 1);
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid.busy", 32'(busy_o), 0);
        chk("rst_mid.fail_cnt", 32'(fail_cnt_o), 0);
        chk("rst_mid.first_fail", 32'(first_fail_o), 0);
        chk("rst_mid.first_fail_ts", 32'(first_fail_ts_o), 0);
        chk("rst_mid.fail_o", 32'(fail_o), 0);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0);
            chk("rst_mid.no_pass", 32'(pass_o), 0);
            chk("rst_mid.no_fail", 32'(fail_o), 0);
        end

        // saturation on the 4-bit instance, then clear
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        chk("sat.small_pass_cnt", 32'(s_pass_cnt_o), 15);
        chk("sat.wide_pass_cnt", 32'(pass_cnt_o), 20);
        step(1, 0, 0, 1);
        chk("sat.small_fail_cnt", 32'(s_fail_cnt_o), 1);
        chk("sat.small_first_fail", 32'(s_first_fail_o), 1);
        step(0, 1, 0, 0);
        chk("clr.small_pass_cnt", 32'(s_pass_cnt_o), 0);
        chk("clr.small_fail_cnt", 32'(s_fail_cnt_o), 0);
        chk("clr.small_first_fail", 32'(s_first_fail_o), 0);
        chk("clr.wide_pass_cnt", 32'(pass_cnt_o), 0);

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            step(($urandom % 8) != 0, ($urandom % 40) == 0, $urandom % 2, $urandom % 2);
        end
        for (int i = 0; i < DELAY + 1; i++) step(0, 0, 0, 0);
        chk("rand.busy_drained", 32'(busy_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
